// File: rtl/shift_pkg.sv
// Shared definitions for the LSB-first serial-to-parallel deserializer.
package shift_pkg;

   localparam int unsigned WIDTH_DEFAULT = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Bits needed to hold a count of 0..w inclusive.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bit_counter.sv
// Counts accepted bits of the current word; tc flags the last bit of a word.
module bit_counter
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   logic [CNT_W-1:0] count_q, count_d;

   assign tc = (count_q == CNT_W'(WIDTH - 1));

   // The bit that would make the count reach WIDTH wraps it straight back to 0.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = tc ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/shift_r_deserializer.sv
// Shift-right deserializer: assembles WIDTH serial bits (LSB first) into a held output word
// with a valid/ready handoff and a sticky overrun flag.
module shift_r_deserializer
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             clr,
   output logic [WIDTH-1:0] shreg,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             ovf
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             out_valid_q, out_valid_d;
   logic             ovf_q, ovf_d;

   logic accept;
   logic tc;
   logic word_done;
   logic handshake;

   assign accept    = sin_valid & ~clr;
   assign word_done = accept & tc;
   assign handshake = out_valid_q & out_ready;

   bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (accept),
      .tc  (tc)
   );

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = IDLE;
      end else if (accept) begin
         unique case (state_q)
            IDLE:    state_d = SHIFT;
            SHIFT:   state_d = tc ? IDLE : SHIFT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      shreg_d = shreg_q;
      if (clr) begin
         shreg_d = '0;
      end else if (accept) begin
         shreg_d = {sin, shreg_q[WIDTH-1:1]};
      end
   end

   // A completed word is dropped only if the held word is still unconsumed this edge.
   always_comb begin
      data_out_d  = data_out_q;
      out_valid_d = out_valid_q;
      ovf_d       = clr ? 1'b0 : ovf_q;
      if (word_done) begin
         if (out_valid_q && !out_ready) begin
            ovf_d = 1'b1;
         end else begin
            data_out_d  = shreg_d;
            out_valid_d = 1'b1;
         end
      end else if (handshake) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign shreg     = shreg_q;
   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == SHIFT);
   assign ovf       = ovf_q;

endmodule
